lr5_matrix_frame_loader: RTL and testbench
==========================================

LR5_MATRIX_FRAME_LOADER -- requirements
Module: lr5_matrix_frame_loader

Interface
REQ-001 SHALL have parameter SCROLL_DIV, default 8, meaning the number of CE pulses per one-column scroll step (used only under LR5_SCROLL_EN).
REQ-002 SHALL have ports, clock and reset first:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-low reset.
- CE  in  1  frame-boundary strobe, one CLK wide.
- WR_STB  in  1  row write strobe.
- WR_ADDR  in  3  row index 0..7.
- WR_DAT  in  8  row pixels.
- WR_RDY  out  1  write accepted when high.
- COMMIT  in  1  request shadow-to-active swap.
- BUSY  out  1  swap pending.
- FRAME_VLD  out  1  one-cycle pulse on swap.
- DAT_O  out  64  active frame to the matrix display driver.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-004 SHALL hold an 8x8-bit shadow buffer and a 64-bit active register driving DAT_O directly, with zero combinational path from the write port.
REQ-005 SHALL map row r to DAT_O[8r+7:8r].
REQ-006 SHALL implement FSM states IDLE, PEND and SWAP.
REQ-007 IDLE: WR_RDY=1; WR_STB writes WR_DAT into shadow[WR_ADDR] on that edge; COMMIT -> PEND.
REQ-008 WR_STB and COMMIT in the same cycle SHALL write first; the committed frame includes that row.
REQ-009 PEND: WR_RDY=0, BUSY=1; WR_STB is ignored and the shadow is frozen; CE -> SWAP.
REQ-010 SWAP: DAT_O <= shadow, FRAME_VLD=1 for exactly one cycle, then -> IDLE; the total latency from a CE sample in PEND to the new DAT_O is 1 cycle.
REQ-011 COMMIT received while in PEND or SWAP SHALL be ignored and SHALL NOT queue.
REQ-012 CE in IDLE SHALL leave DAT_O unchanged.
REQ-013 Rows that are never written SHALL keep their previous shadow contents; the shadow is not cleared on swap.

Reset
REQ-014 RST low SHALL asynchronously force:
- state=IDLE
- shadow=0
- DAT_O=64'h0
- FRAME_VLD=0
- BUSY=0
- WR_RDY=1
- scroll offset=0
REQ-015 Reset asserted during PEND SHALL discard the pending swap.
REQ-016 Release SHALL be sampled synchronously; the first write is accepted on the first edge after release.

Configuration
REQ-017 Macro LR5_SCROLL_EN defined:
- a 3-bit offset increments every SCROLL_DIV CE pulses while in IDLE.
- DAT_O row r = shadow-derived active row r rotated left by offset.
- offset wraps 7->0.
- a swap resets offset to 0.
REQ-018 Macro LR5_SCROLL_EN undefined: no offset logic, no divider; DAT_O = active register unrotated; SCROLL_DIV unused.

Structure
REQ-019 Package lr5_matrix_pkg SHALL hold:
- constants ROWS=8, COLS=8, FRAME_W=64.
- the FSM state typedef.
- the row index typedef.
REQ-020 Sub-module lr5_ce_div SHALL count CE pulses modulo SCROLL_DIV, produce a one-cycle step pulse, and be instantiated only under LR5_SCROLL_EN.

Verification
REQ-021 Write rows 0..7 = 8'h01,02,04,08,10,20,40,80, COMMIT, CE -> DAT_O=64'h8040201008040201 one cycle after CE; FRAME_VLD pulses once.
REQ-022 COMMIT, then WR_STB row 0 = 8'hFF before CE -> write ignored, WR_RDY=0, BUSY=1; DAT_O row 0 keeps the committed value after the swap.
REQ-023 WR_STB row 3 = 8'hAA with COMMIT in the same cycle, then CE -> DAT_O[31:24]=8'hAA.
REQ-024 RST low during PEND, release, CE -> DAT_O=0, FRAME_VLD never pulses, BUSY=0.
REQ-025 Ten CE pulses with no COMMIT in IDLE -> DAT_O constant and FRAME_VLD stays 0.
REQ-026 With LR5_SCROLL_EN and SCROLL_DIV=2, frame row 0 = 8'h01 -> after 4 CE pulses row 0 = 8'h04; after 16 CE pulses row 0 = 8'h01 (wrap).

Source files
------------

// File: rtl/lr5_matrix_pkg.sv
// Shared constants and types for the LR5 8x8 matrix frame loader.
// The optional scroll feature is enabled by defining LR5_SCROLL_EN.
package lr5_matrix_pkg;

  localparam int ROWS    = 8;
  localparam int COLS    = 8;
  localparam int FRAME_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_SWAP = 2'd2
  } state_t;

  typedef logic [2:0] row_idx_t;

endpackage

// File: rtl/lr5_ce_div.sv
// Divides CE pulses by SCROLL_DIV and emits a one-cycle step pulse.
// Instantiated only when LR5_SCROLL_EN is defined.
module lr5_ce_div #(
  parameter int SCROLL_DIV = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic en,
  input  logic clr,
  input  logic ce,
  output logic step
);

  localparam int CNT_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCROLL_DIV - 1);

  logic [CNT_W-1:0] cnt_r;

  // CE counter modulo SCROLL_DIV; clr restarts the scroll period.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_r <= '0;
      step  <= 1'b0;
    end else begin
      step <= 1'b0;
      if (clr) begin
        cnt_r <= '0;
      end else if (en && ce) begin
        if (cnt_r == CNT_LAST) begin
          cnt_r <= '0;
          step  <= 1'b1;
        end else begin
          cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

endmodule

// File: rtl/lr5_matrix_frame_loader.sv
// Double-buffered 8x8 frame loader: rows go to a shadow buffer, COMMIT + CE swap it to DAT_O.
// Define LR5_SCROLL_EN to rotate every displayed row left by a CE-driven column offset.
module lr5_matrix_frame_loader
  import lr5_matrix_pkg::*;
#(
  parameter int SCROLL_DIV = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CE,
  input  logic               WR_STB,
  input  row_idx_t           WR_ADDR,
  input  logic [COLS-1:0]    WR_DAT,
  output logic               WR_RDY,
  input  logic               COMMIT,
  output logic               BUSY,
  output logic               FRAME_VLD,
  output logic [FRAME_W-1:0] DAT_O
);

  state_t                      state_r;
  logic [ROWS-1:0][COLS-1:0]   shadow_r;
  logic [ROWS-1:0][COLS-1:0]   active_r;

  if (SCROLL_DIV < 1) begin : g_bad_scroll_div
    $error("lr5_matrix_frame_loader: SCROLL_DIV must be at least 1");
  end

  // Frame FSM: shadow writes in IDLE, frozen in PEND until CE, one-cycle SWAP.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r   <= ST_IDLE;
      shadow_r  <= '0;
      active_r  <= '0;
      FRAME_VLD <= 1'b0;
      BUSY      <= 1'b0;
      WR_RDY    <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          FRAME_VLD <= 1'b0;
          if (WR_STB) begin
            shadow_r[WR_ADDR] <= WR_DAT;
          end
          if (COMMIT) begin
            state_r <= ST_PEND;
            BUSY    <= 1'b1;
            WR_RDY  <= 1'b0;
          end
        end
        ST_PEND: begin
          if (CE) begin
            state_r   <= ST_SWAP;
            active_r  <= shadow_r;
            FRAME_VLD <= 1'b1;
          end
        end
        ST_SWAP: begin
          state_r   <= ST_IDLE;
          FRAME_VLD <= 1'b0;
          BUSY      <= 1'b0;
          WR_RDY    <= 1'b1;
        end
        default: begin
          state_r   <= ST_IDLE;
          FRAME_VLD <= 1'b0;
          BUSY      <= 1'b0;
          WR_RDY    <= 1'b1;
        end
      endcase
    end
  end

`ifdef LR5_SCROLL_EN
  logic                      swap_s;
  logic                      step_s;
  logic [2:0]                offset_r;
  logic [15:0]               rot_row_s;
  logic [ROWS-1:0][COLS-1:0] rot_s;

  assign swap_s = (state_r == ST_PEND) && CE;

  lr5_ce_div #(
    .SCROLL_DIV (SCROLL_DIV)
  ) u_ce_div (
    .CLK  (CLK),
    .RST  (RST),
    .en   (state_r == ST_IDLE),
    .clr  (swap_s),
    .ce   (CE),
    .step (step_s)
  );

  // Column offset: restarts on every swap, wraps naturally at 3 bits.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      offset_r <= 3'd0;
    end else if (swap_s) begin
      offset_r <= 3'd0;
    end else if (step_s) begin
      offset_r <= offset_r + 3'd1;
    end else begin
      offset_r <= offset_r;
    end
  end

  // Rotate each active row left by the current offset.
  always_comb begin
    rot_s     = '0;
    rot_row_s = 16'h0000;
    for (int r = 0; r < ROWS; r++) begin
      rot_row_s = {active_r[r], active_r[r]} << offset_r;
      rot_s[r]  = rot_row_s[15:8];
    end
  end

  assign DAT_O = rot_s;
`else
  assign DAT_O = active_r;
`endif

endmodule

// File: tb/tb_lr5_matrix_frame_loader.sv
// Directed + random bench for lr5_matrix_frame_loader against a frame-level reference model.
// Scroll checks are included when LR5_SCROLL_EN is defined.
module tb_lr5_matrix_frame_loader;

  localparam int TB_DIV = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        CE = 1'b0;
  logic        WR_STB = 1'b0;
  logic [2:0]  WR_ADDR = 3'd0;
  logic [7:0]  WR_DAT = 8'h00;
  logic        WR_RDY;
  logic        COMMIT = 1'b0;
  logic        BUSY;
  logic        FRAME_VLD;
  logic [63:0] DAT_O;

  int errors = 0;
  int checks = 0;

  // reference model: shadow rows, displayed frame, swap progress, scroll offset
  logic [7:0] m_shadow [8];
  logic [7:0] m_active [8];
  bit         m_pending;
  bit         m_in_swap;
  int         m_offset;
  int         m_divcnt;

  lr5_matrix_frame_loader #(.SCROLL_DIV(TB_DIV)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .CE        (CE),
    .WR_STB    (WR_STB),
    .WR_ADDR   (WR_ADDR),
    .WR_DAT    (WR_DAT),
    .WR_RDY    (WR_RDY),
    .COMMIT    (COMMIT),
    .BUSY      (BUSY),
    .FRAME_VLD (FRAME_VLD),
    .DAT_O     (DAT_O)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 8; r++) begin
      m_shadow[r] = 8'h00;
      m_active[r] = 8'h00;
    end
    m_pending = 1'b0;
    m_in_swap = 1'b0;
    m_offset  = 0;
    m_divcnt  = 0;
  endtask

  function automatic logic [63:0] exp_frame();
    logic [63:0] f;
    int          v;
    f = 64'h0;
    for (int r = 0; r < 8; r++) begin
      v = int'(m_active[r]);
`ifdef LR5_SCROLL_EN
      v = ((v << m_offset) | (v >> (8 - m_offset))) & 255;
`endif
      f[8*r +: 8] = v[7:0];
    end
    return f;
  endfunction

  // one clock edge of the frame-loader rules
  task automatic model_edge(input bit ce, input bit wr, input logic [2:0] a,
                            input logic [7:0] d, input bit cm);
    if (m_in_swap) begin
      m_in_swap = 1'b0;
    end else if (m_pending) begin
      if (ce) begin
        for (int r = 0; r < 8; r++) m_active[r] = m_shadow[r];
        m_pending = 1'b0;
        m_in_swap = 1'b1;
        m_offset  = 0;
        m_divcnt  = 0;
      end
    end else begin
      if (wr) m_shadow[a] = d;
      if (ce) begin
        m_divcnt++;
        if (m_divcnt == TB_DIV) begin
          m_divcnt = 0;
          m_offset = (m_offset + 1) % 8;
        end
      end
      if (cm) m_pending = 1'b1;
    end
  endtask

  task automatic check_outputs(input bit chk_dat);
    chk("frame_vld", {63'h0, FRAME_VLD}, {63'h0, m_in_swap});
    chk("busy", {63'h0, BUSY}, {63'h0, (m_pending || m_in_swap)});
    chk("wr_rdy", {63'h0, WR_RDY}, {63'h0, !(m_pending || m_in_swap)});
    if (chk_dat) chk("dat_o", DAT_O, exp_frame());
  endtask

  task automatic tick(input bit ce, input bit wr, input logic [2:0] a,
                      input logic [7:0] d, input bit cm);
    bit chk_dat;
    CE = ce; WR_STB = wr; WR_ADDR = a; WR_DAT = d; COMMIT = cm;
    @(negedge CLK);
    model_edge(ce, wr, a, d, cm);
    CE = 1'b0; WR_STB = 1'b0; COMMIT = 1'b0;
    chk_dat = 1'b1;
`ifdef LR5_SCROLL_EN
    chk_dat = !ce;
`endif
    check_outputs(chk_dat);
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst_dat", DAT_O, 64'h0);
    chk("rst_vld", {63'h0, FRAME_VLD}, 64'h0);
    chk("rst_busy", {63'h0, BUSY}, 64'h0);
    chk("rst_rdy", {63'h0, WR_RDY}, 64'h1);
    @(negedge CLK);
    RST = 1'b1;

    // walking-one rows, commit, swap on CE
    for (int r = 0; r < 8; r++) tick(1'b0, 1'b1, 3'(r), 8'(1 << r), 1'b0);
    tick(1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
    tick(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    tick(1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
    chk("walk_dat", DAT_O, 64'h8040201008040201);
    chk("walk_vld", {63'h0, FRAME_VLD}, 64'h1);
    tick(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    chk("walk_vld_end", {63'h0, FRAME_VLD}, 64'h0);

    // write while pending is ignored
    tick(1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
    tick(1'b0, 1'b1, 3'd0, 8'hFF, 1'b0);
    chk("pend_rdy", {63'h0, WR_RDY}, 64'h0);
    chk("pend_busy", {63'h0, BUSY}, 64'h1);
    tick(1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
    tick(1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
    chk("pend_row0", {56'h0, DAT_O[7:0]}, 64'h01);
    tick(1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
    tick(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);

    // write and commit in the same cycle
    tick(1'b0, 1'b1, 3'd3, 8'hAA, 1'b1);
    tick(1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
    chk("same_row3", {56'h0, DAT_O[31:24]}, 64'hAA);
    tick(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);

    // CE with no commit leaves the frame alone
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
      tick(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    end

    // reset while pending drops the swap
    tick(1'b0, 1'b1, 3'd5, 8'h5A, 1'b0);
    tick(1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
    #2 RST = 1'b0;
    model_reset();
    #1;
    chk("rstp_busy", {63'h0, BUSY}, 64'h0);
    chk("rstp_dat", DAT_O, 64'h0);
    @(negedge CLK);
    RST = 1'b1;
    tick(1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
    chk("rstp_ce_dat", DAT_O, 64'h0);
    chk("rstp_ce_vld", {63'h0, FRAME_VLD}, 64'h0);
    tick(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);

`ifdef LR5_SCROLL_EN
    tick(1'b0, 1'b1, 3'd0, 8'h01, 1'b1);
    tick(1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
    tick(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
      tick(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    end
    chk("scroll_4", {56'h0, DAT_O[7:0]}, 64'h04);
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
      tick(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    end
    chk("scroll_16", {56'h0, DAT_O[7:0]}, 64'h01);
`endif

    // random traffic
    for (int i = 0; i < 400; i++) begin
      tick(($urandom % 4) == 0, ($urandom % 2) == 0, 3'($urandom % 8),
           8'($urandom % 256), ($urandom % 8) == 0);
    end
    tick(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
